// File: rtl/key_schedule_engine.sv
// AES key expansion engine: expands a 128/192/256-bit cipher key into a 60-word
// schedule, one word per clock, and serves round keys combinationally.
module key_schedule_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic [3:0]   rd_round,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         keys_valid,
  output logic [3:0]   nr,
  output logic [127:0] round_key
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // FIPS-197 forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]  rstSync_q;
  logic        rstInt_n;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        keysValid_q;
  logic [3:0]  nr_q;
  logic [3:0]  nk_q;
  logic [5:0]  wordIdx_q;
  logic [2:0]  jCnt_q;
  logic [7:0]  rcon_q;
  logic [31:0] words_q [60];

  logic [3:0]  nkSel;
  logic [5:0]  prevIdx;
  logic [5:0]  farIdx;
  logic [5:0]  lastIdx;
  logic [31:0] prevWord;
  logic [31:0] subIn;
  logic [31:0] subOut;
  logic [31:0] temp;
  logic [31:0] newWord_d;
  logic [7:0]  rcon_d;
  logic        jWrap;
  logic [5:0]  rdBase;

  // Assertion is immediate; release is retimed through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];

  assign nkSel   = {1'b0, key_len, 1'b0} + 4'd4;
  assign prevIdx = wordIdx_q - 6'd1;
  assign farIdx  = wordIdx_q - {2'b00, nk_q};
  assign lastIdx = {nr_q, 2'b00} + 6'd3;
  assign jWrap   = ({1'b0, jCnt_q} == (nk_q - 4'd1));

  // One shared SubWord serves both the RotWord step and the extra AES-256 step.
  always_comb begin
    prevWord  = words_q[prevIdx];
    subIn     = (jCnt_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    subOut    = subWord(subIn);
    temp      = prevWord;
    if (jCnt_q == 3'd0)
      temp = subOut ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && jCnt_q == 3'd4)
      temp = subOut;
    newWord_d = words_q[farIdx] ^ temp;
    rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      keysValid_q <= 1'b0;
      nr_q        <= 4'd0;
      nk_q        <= 4'd0;
      wordIdx_q   <= 6'd0;
      jCnt_q      <= 3'd0;
      rcon_q      <= 8'd0;
      for (int k = 0; k < 60; k++) words_q[k] <= 32'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (key_len == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              for (int k = 0; k < 8; k++)
                if (k < int'(nkSel)) words_q[k] <= key[255 - 32*k -: 32];
              wordIdx_q   <= {2'b00, nkSel};
              jCnt_q      <= 3'd0;
              rcon_q      <= 8'h01;
              nk_q        <= nkSel;
              nr_q        <= nkSel + 4'd6;
              keysValid_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          words_q[wordIdx_q] <= newWord_d;
          wordIdx_q          <= wordIdx_q + 6'd1;
          jCnt_q             <= jWrap ? 3'd0 : jCnt_q + 3'd1;
          if (jCnt_q == 3'd0) rcon_q <= rcon_d;
          if (wordIdx_q == lastIdx) begin
            done_q      <= 1'b1;
            keysValid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdBase = {rd_round, 2'b00};

  always_comb begin
    round_key = '0;
    if (rd_round <= nr_q)
      round_key = {words_q[rdBase], words_q[rdBase + 6'd1],
                   words_q[rdBase + 6'd2], words_q[rdBase + 6'd3]};
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign keys_valid = keysValid_q;
  assign nr         = nr_q;

endmodule

// File: tb/tb_key_schedule_engine.sv
// Self-checking bench for key_schedule_engine: fixed FIPS-197 vectors plus
// randomized keys compared against a behavioural key-expansion model.
module tb_key_schedule_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   nr;
  logic [127:0] round_key;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sboxRef [256];
  logic [31:0] modelW [60];
  int          modelNr;

  key_schedule_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .key        (key),
    .rd_round   (rd_round),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .keys_valid (keys_valid),
    .nr         (nr),
    .round_key  (round_key)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15 - n -: 8];
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map, not a table.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      if (b != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(b));
      end
      sboxRef[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordRef(input logic [31:0] w);
    return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
  endfunction

  task automatic modelExpand(input logic [1:0] kl, input logic [255:0] k);
    int nk;
    int total;
    logic [7:0]  rc;
    logic [31:0] t;
    nk      = 4 + 2 * int'(kl);
    modelNr = nk + 6;
    total   = 4 * (modelNr + 1);
    rc      = 8'h01;
    for (int i = 0; i < nk; i++) modelW[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = modelW[i - 1];
      if (i % nk == 0) begin
        t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subWordRef(t);
      end
      modelW[i] = modelW[i - nk] ^ t;
    end
  endtask

  function automatic logic [127:0] modelRoundKey(input int r);
    if (r > modelNr) return '0;
    return {modelW[4*r], modelW[4*r+1], modelW[4*r+2], modelW[4*r+3]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 60; i++) modelW[i] = 32'd0;
    modelNr = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k);
    key_len = kl;
    key     = k;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int r, input logic [127:0] expected);
    rd_round = 4'(r);
    #1;
    checkOutput(tag, round_key, expected);
  endtask

  task automatic checkAllRounds(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_round = 4'(r);
      #0.5;
      checkOutput($sformatf("%s rk%0d", tag, r), round_key, modelRoundKey(r));
    end
    @(posedge clk); #1;
  endtask

  // Starts a run, measures latency, checks the done pulse; ends one edge after done.
  task automatic runAndCheck(input string tag, input logic [1:0] kl, input logic [255:0] k, input int pokeAt);
    int nk;
    int cycles;
    nk = 4 + 2 * int'(kl);
    applyStimulus(kl, k);
    cycles = 1;
    checkOutput({tag, " busy@start"}, busy, 1'b1);
    checkOutput({tag, " valid@start"}, keys_valid, 1'b0);
    checkOutput({tag, " nr@start"}, nr, nk + 6);
    do begin
      @(posedge clk); #1;
      cycles++;
      if (pokeAt != 0 && cycles == pokeAt) begin
        key_len = 2'(($urandom_range(0, 2)));
        key     = ~k;
        start   = 1'b1;
      end else begin
        start   = 1'b0;
      end
    end while (!done && cycles < 100);
    start = 1'b0;
    modelExpand(kl, k);
    checkOutput({tag, " latency"}, cycles, 3 * nk + 29);
    checkOutput({tag, " valid@done"}, keys_valid, 1'b1);
    checkOutput({tag, " busy@done"}, busy, 1'b1);
    checkOutput({tag, " nr@done"}, nr, modelNr);
    @(posedge clk); #1;
    checkOutput({tag, " done pulse"}, done, 1'b0);
    checkOutput({tag, " busy@idle"}, busy, 1'b0);
    checkOutput({tag, " valid@idle"}, keys_valid, 1'b1);
  endtask

  initial begin
    int  cycles;
    bit  sawDone;
    logic [1:0]   kl;
    logic [255:0] k;

    rst_n    = 1'b0;
    start    = 1'b0;
    key_len  = 2'b00;
    key      = '0;
    rd_round = 4'd0;
    buildSbox();
    modelReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset valid", keys_valid, 1'b0);
    checkOutput("reset nr", nr, 4'd0);
    readCheck("reset rk0", 0, modelRoundKey(0));
    readCheck("reset rk5", 5, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    runAndCheck("aes128", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 0);
    checkOutput("aes128 nr", nr, 4'd10);
    readCheck("aes128 rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readCheck("aes128 rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    @(posedge clk); #1;
    checkAllRounds("aes128");

    runAndCheck("aes192", 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0}, 0);
    checkOutput("aes192 nr", nr, 4'd12);
    readCheck("aes192 rk12", 12, 128'he98ba06f448c773c8ecc720401002202);
    @(posedge clk); #1;
    checkAllRounds("aes192");

    runAndCheck("aes256", 2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0);
    checkOutput("aes256 nr", nr, 4'd14);
    readCheck("aes256 rk14", 14, 128'hfe4890d1e6188d0b046df344706c631e);
    @(posedge clk); #1;

    applyStimulus(2'b11, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    checkOutput("illegal err", err, 1'b1);
    checkOutput("illegal busy", busy, 1'b0);
    checkOutput("illegal valid", keys_valid, 1'b1);
    checkOutput("illegal nr", nr, 4'd14);
    @(posedge clk); #1;
    checkOutput("illegal err pulse", err, 1'b0);
    checkOutput("illegal busy later", busy, 1'b0);
    readCheck("rk15 zero", 15, 128'd0);
    checkAllRounds("illegal retained");

    runAndCheck("busystart", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 10);
    readCheck("busystart rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    checkOutput("busystart no queue", busy, 1'b0);

    // Abort an AES-256 expansion part-way through.
    applyStimulus(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    cycles = 1;
    while (cycles < 20) begin @(posedge clk); #1; cycles++; end
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst done", done, 1'b0);
    checkOutput("midrst err", err, 1'b0);
    checkOutput("midrst valid", keys_valid, 1'b0);
    checkOutput("midrst nr", nr, 4'd0);
    readCheck("midrst rk0", 0, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("midrst no done", sawDone, 1'b0);
    checkOutput("midrst valid after", keys_valid, 1'b0);
    checkOutput("midrst busy after", busy, 1'b0);
    runAndCheck("post-reset aes128", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0}, 0);
    readCheck("post-reset rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readCheck("post-reset rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    @(posedge clk); #1;

    // Random keys issued back-to-back at the minimum period.
    for (int n = 0; n < 12; n++) begin
      kl = 2'($urandom_range(0, 3));
      k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (kl == 2'b11) begin
        applyStimulus(kl, k);
        checkOutput($sformatf("rand%0d err", n), err, 1'b1);
        checkOutput($sformatf("rand%0d err busy", n), busy, 1'b0);
      end else begin
        runAndCheck($sformatf("rand%0d", n), kl, k, 0);
        for (int m = 0; m < 6; m++) begin
          int r;
          r = $urandom_range(0, 15);
          readCheck($sformatf("rand%0d rk%0d", n, r), r, modelRoundKey(r));
        end
      end
    end
    @(posedge clk); #1;
    checkAllRounds("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
